// File: rtl/rpc_ctrl_pkg.sv
// Shared types for the RPC DRAM link: opcodes, decoded command frame, responder FSM states.
package rpc_ctrl_pkg;

  localparam int unsigned RpcDataW        = 16;
  localparam int unsigned RpcBankW        = 2;
  localparam int unsigned RpcRowW         = 10;
  localparam int unsigned RpcColW         = 6;
  localparam int unsigned RpcLenW         = 6;
  localparam int unsigned RpcNumBanks     = 4;
  localparam int unsigned RpcBeatsPerUnit = 16;
  localparam int unsigned RpcBeatCntW     = 10;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ACT = 4'd1,
    OP_WR  = 4'd2,
    OP_RD  = 4'd3,
    OP_PRE = 4'd4
  } rpc_op_e;

  typedef struct packed {
    rpc_op_e              op;
    logic [RpcBankW-1:0]  bank;
    logic [RpcRowW-1:0]   row;
    logic [RpcColW-1:0]   col;
    logic [RpcLenW-1:0]   len;
  } rpc_cmd_t;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_CMD1,
    RSP_WR_WAIT,
    RSP_WR_DATA,
    RSP_RD_WAIT,
    RSP_RD_DATA
  } rsp_state_e;

  // beat1 [3:0] is reserved and dropped here
  function automatic rpc_cmd_t rpc_decode(input logic [RpcDataW-1:0] beat0,
                                          input logic [RpcDataW-1:0] beat1);
    rpc_cmd_t c;
    c.op   = rpc_op_e'(beat0[15:12]);
    c.bank = beat0[11:10];
    c.row  = beat0[9:0];
    c.col  = beat1[15:10];
    c.len  = beat1[9:4];
    return c;
  endfunction

  // Index of the final beat of a (len+1)*RpcBeatsPerUnit burst
  function automatic logic [RpcBeatCntW-1:0] rpc_last_beat(input logic [RpcLenW-1:0] len);
    return RpcBeatCntW'(({4'b0000, len} + 10'd1) * RpcBeatCntW'(RpcBeatsPerUnit) - 10'd1);
  endfunction

endpackage

// File: rtl/rpc_resp_mem.sv
// Single-port synchronous backing store, one-cycle read latency, write-first.
module rpc_resp_mem #(
  parameter int unsigned Depth = 4096,
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rpc_dram_responder.sv
// Device-side RPC DRAM responder: command decode, per-bank open-row table,
// write-burst capture and fixed-latency read-burst return.
module rpc_dram_responder
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned MemDepth     = 4096,
  parameter int unsigned WriteLatency = 2,
  parameter int unsigned ReadLatency  = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rpc_cs_ni,
  input  logic                rpc_stb_i,
  input  logic [RpcDataW-1:0] phy_db_i,
  input  logic                phy_dqs_i,
  output logic [RpcDataW-1:0] phy_db_o,
  output logic                phy_dqs_o,
  output logic                phy_db_oe_o,
  output logic                phy_dqs_oe_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int unsigned AddrW  = $clog2(MemDepth);
  localparam int unsigned LatMax = (WriteLatency > ReadLatency) ? WriteLatency : ReadLatency;
  localparam int unsigned LatW   = $clog2(LatMax + 1);

  rsp_state_e               state_q;
  logic [RpcDataW-1:0]      beat0_q;
  logic [RpcBankW-1:0]      bank_q;
  logic [RpcColW-1:0]       col_q;
  logic [RpcLenW-1:0]       len_q;
  logic                     drop_q;
  logic [LatW-1:0]          lat_q;
  logic [RpcBeatCntW-1:0]   beat_q;
  logic [RpcRowW-1:0]       open_row_q [RpcNumBanks];
  logic [RpcNumBanks-1:0]   row_valid_q;

  rpc_cmd_t                 cmd_c;
  logic                     row_hit_c;
  logic [RpcBeatCntW-1:0]   last_c;
  logic [31:0]              base_c;
  logic [31:0]              rd_idx_c;
  logic [AddrW-1:0]         mem_addr_c;
  logic                     mem_we_c;
  logic [RpcDataW-1:0]      mem_rdata;

  assign cmd_c     = rpc_decode(beat0_q, phy_db_i);
  assign row_hit_c = row_valid_q[cmd_c.bank] && (open_row_q[cmd_c.bank] == cmd_c.row);
  assign last_c    = rpc_last_beat(len_q);
  assign base_c    = 32'({bank_q, col_q, 4'b0000});

  // Reads run two beats ahead of the output register (RAM latency + output flop)
  assign rd_idx_c  = (state_q == RSP_RD_DATA) ? (32'(beat_q) + 32'd2)
                                              : (32'(lat_q) - (32'(ReadLatency) - 32'd2));
  assign mem_addr_c = AddrW'(base_c + ((state_q == RSP_WR_DATA) ? 32'(beat_q) : rd_idx_c));
  assign mem_we_c   = (state_q == RSP_WR_DATA) && phy_dqs_i && !rpc_cs_ni && !drop_q;

  rpc_resp_mem #(
    .Depth (MemDepth),
    .DataW (RpcDataW),
    .AddrW (AddrW)
  ) u_mem (
    .clk_i (clk_i),
    .we    (mem_we_c),
    .addr  (mem_addr_c),
    .wdata (phy_db_i),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RSP_IDLE;
      beat0_q      <= '0;
      bank_q       <= '0;
      col_q        <= '0;
      len_q        <= '0;
      drop_q       <= 1'b0;
      lat_q        <= '0;
      beat_q       <= '0;
      row_valid_q  <= '0;
      for (int b = 0; b < int'(RpcNumBanks); b++) open_row_q[b] <= '0;
      phy_db_o     <= '0;
      phy_dqs_o    <= 1'b0;
      phy_db_oe_o  <= 1'b0;
      phy_dqs_oe_o <= 1'b0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      err_o        <= 1'b0;
      phy_db_o     <= '0;
      phy_dqs_o    <= 1'b0;
      phy_db_oe_o  <= 1'b0;
      phy_dqs_oe_o <= 1'b0;
      busy_o       <= 1'b1;
      if (rpc_cs_ni) begin
        state_q <= RSP_IDLE;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          RSP_IDLE: begin
            if (rpc_stb_i) begin
              beat0_q <= phy_db_i;
              state_q <= RSP_CMD1;
            end else begin
              busy_o <= 1'b0;
            end
          end
          RSP_CMD1: begin
            state_q <= RSP_IDLE;
            busy_o  <= 1'b0;
            if (rpc_stb_i) begin
              bank_q <= cmd_c.bank;
              col_q  <= cmd_c.col;
              len_q  <= cmd_c.len;
              lat_q  <= '0;
              beat_q <= '0;
              drop_q <= !row_hit_c;
              case (cmd_c.op)
                OP_NOP: begin end
                OP_ACT: begin
                  open_row_q[cmd_c.bank]  <= cmd_c.row;
                  row_valid_q[cmd_c.bank] <= 1'b1;
                end
                OP_PRE: row_valid_q[cmd_c.bank] <= 1'b0;
                OP_WR: begin
                  state_q <= RSP_WR_WAIT;
                  busy_o  <= 1'b1;
                  err_o   <= !row_hit_c;
                end
                OP_RD: begin
                  state_q <= RSP_RD_WAIT;
                  busy_o  <= 1'b1;
                  err_o   <= !row_hit_c;
                end
                default: err_o <= 1'b1;
              endcase
            end
          end
          RSP_WR_WAIT: begin
            if (lat_q == LatW'(WriteLatency - 1)) state_q <= RSP_WR_DATA;
            else                                  lat_q   <= lat_q + LatW'(1);
          end
          RSP_WR_DATA: begin
            if (phy_dqs_i) begin
              if (beat_q == last_c) begin
                state_q <= RSP_IDLE;
                busy_o  <= 1'b0;
              end else begin
                beat_q <= beat_q + RpcBeatCntW'(1);
              end
            end
          end
          RSP_RD_WAIT: begin
            if (lat_q == LatW'(ReadLatency - 1)) begin
              state_q      <= RSP_RD_DATA;
              phy_db_o     <= drop_q ? '0 : mem_rdata;
              phy_dqs_o    <= !drop_q;
              phy_db_oe_o  <= !drop_q;
              phy_dqs_oe_o <= !drop_q;
            end else begin
              lat_q <= lat_q + LatW'(1);
            end
          end
          RSP_RD_DATA: begin
            if (beat_q == last_c) begin
              state_q <= RSP_IDLE;
              busy_o  <= 1'b0;
            end else begin
              beat_q       <= beat_q + RpcBeatCntW'(1);
              phy_db_o     <= drop_q ? '0 : mem_rdata;
              phy_dqs_o    <= !drop_q;
              phy_db_oe_o  <= !drop_q;
              phy_dqs_oe_o <= !drop_q;
            end
          end
          default: begin
            state_q <= RSP_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rpc_dram_responder.sv
// Directed bench for rpc_dram_responder: closed-loop command/write/read frames with fixed expectations.
module tb_rpc_dram_responder;

  localparam int unsigned WL = 2;
  localparam int unsigned RL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        stb;
  logic [15:0] db_i;
  logic        dqs_i;
  logic [15:0] db_o;
  logic        dqs_o;
  logic        db_oe;
  logic        dqs_oe;
  logic        err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] cap_data [64];
  int          cap_n;
  int          cap_first;
  bit          cap_bad;

  always #5 clk = ~clk;

  rpc_dram_responder #(
    .MemDepth     (4096),
    .WriteLatency (WL),
    .ReadLatency  (RL)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rpc_cs_ni    (cs_n),
    .rpc_stb_i    (stb),
    .phy_db_i     (db_i),
    .phy_dqs_i    (dqs_i),
    .phy_db_o     (db_o),
    .phy_dqs_o    (dqs_o),
    .phy_db_oe_o  (db_oe),
    .phy_dqs_oe_o (dqs_oe),
    .err_o        (err),
    .busy_o       (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that samples beat1
  task automatic send_cmd(input logic [3:0] op, input logic [1:0] bank, input logic [9:0] row,
                          input logic [5:0] col, input logic [5:0] len);
    cs_n = 1'b0;
    stb  = 1'b1;
    db_i = {op, bank, row};
    tick();
    db_i = {col, len, 4'h0};
    tick();
    stb  = 1'b0;
    db_i = '0;
  endtask

  task automatic write_burst(input logic [1:0] bank, input logic [9:0] row, input logic [5:0] col,
                             input logic [5:0] len, input logic [15:0] seed, input int nbeats,
                             output logic err_seen);
    send_cmd(4'd2, bank, row, col, len);
    err_seen = err;
    repeat (WL) tick();
    for (int k = 0; k < nbeats; k++) begin
      dqs_i = 1'b1;
      db_i  = seed + 16'(k);
      tick();
    end
    dqs_i = 1'b0;
    db_i  = '0;
    tick();
  endtask

  task automatic read_capture(input logic [1:0] bank, input logic [9:0] row, input logic [5:0] col,
                              input logic [5:0] len, output logic err_seen);
    for (int k = 0; k < 64; k++) cap_data[k] = 16'hxxxx;
    cap_n     = 0;
    cap_first = -1;
    cap_bad   = 1'b0;
    send_cmd(4'd3, bank, row, col, len);
    err_seen = err;
    for (int j = 1; j <= int'(RL) + (int'(len) + 1) * 16 + 3; j++) begin
      tick();
      if (db_oe !== dqs_o || dqs_oe !== dqs_o) cap_bad = 1'b1;
      if (dqs_o === 1'b1) begin
        if (cap_n < 64) cap_data[cap_n] = db_o;
        if (cap_n == 0) cap_first = j;
        cap_n++;
      end else if (db_o !== 16'h0000) begin
        cap_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    stb   = 1'b0;
    db_i  = '0;
    dqs_i = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({db_o, dqs_o, db_oe, dqs_oe, err, busy} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {db_o, dqs_o, db_oe, dqs_oe, err, busy});
    end
    rst_n = 1'b1;
    cs_n  = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    logic e;
    send_cmd(4'd1, 2'd0, 10'd5, 6'd0, 6'd0);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL act_err: got %b want 0", err); end
    tick();
    write_burst(2'd0, 10'd5, 6'd2, 6'd0, 16'h1000, 16, e);
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b want 0", e); end
    read_capture(2'd0, 10'd5, 6'd2, 6'd0, e);
    vectors++;
    if ({e, cap_bad} !== 2'b00) begin miscompares++; $display("FAIL rd_err_oe: got %b want 00", {e, cap_bad}); end
    vectors++;
    if (cap_n !== 16) begin miscompares++; $display("FAIL rd_beats: got %0d want 16", cap_n); end
    vectors++;
    if (cap_first !== int'(RL)) begin miscompares++; $display("FAIL rd_latency: got %0d want %0d", cap_first, RL); end
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (cap_data[k] !== 16'h1000 + 16'(k)) begin
        miscompares++;
        $display("FAIL rd_data[%0d]: got %h want %h", k, cap_data[k], 16'h1000 + 16'(k));
      end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_rd_closed();
    send_cmd(4'd3, 2'd1, 10'd0, 6'd0, 6'd0);
    vectors++;
    if ({err, busy} !== 2'b11) begin miscompares++; $display("FAIL closed_err_busy: got %b want 11", {err, busy}); end
    for (int j = 1; j <= int'(RL) + 18; j++) begin
      logic exp_busy;
      tick();
      exp_busy = (j < int'(RL) + 16);
      vectors++;
      if ({err, dqs_o, db_oe, dqs_oe, db_o, busy} !== {4'b0000, 16'h0000, exp_busy}) begin
        miscompares++;
        $display("FAIL closed_window[%0d]: got err=%b dqs=%b oe=%b/%b db=%h busy=%b want busy=%b others 0",
                 j, err, dqs_o, db_oe, dqs_oe, db_o, busy, exp_busy);
      end
    end
  endtask

  task automatic test_cs_abort();
    logic e;
    write_burst(2'd0, 10'd5, 6'd2, 6'd0, 16'h2000, 16, e);
    send_cmd(4'd2, 2'd0, 10'd5, 6'd2, 6'd0);
    repeat (WL) tick();
    for (int k = 0; k < 8; k++) begin
      dqs_i = 1'b1;
      db_i  = 16'h3000 + 16'(k);
      tick();
    end
    cs_n  = 1'b1;
    db_i  = 16'h3008;
    tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    cs_n  = 1'b0;
    dqs_i = 1'b0;
    db_i  = '0;
    tick();
    read_capture(2'd0, 10'd5, 6'd2, 6'd0, e);
    vectors++;
    if ({e, cap_bad, cap_n} !== {2'b00, 32'd16}) begin
      miscompares++;
      $display("FAIL abort_reread: got err=%b bad=%b beats=%0d want 0 0 16", e, cap_bad, cap_n);
    end
    for (int k = 0; k < 16; k++) begin
      logic [15:0] exp;
      exp = (k < 8) ? 16'h3000 + 16'(k) : 16'h2000 + 16'(k);
      vectors++;
      if (cap_data[k] !== exp) begin
        miscompares++;
        $display("FAIL abort_word[%0d]: got %h want %h", k, cap_data[k], exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic e;
    send_cmd(4'd1, 2'd3, 10'd9, 6'd0, 6'd0);
    tick();
    write_burst(2'd3, 10'd9, 6'd63, 6'd1, 16'h4000, 32, e);
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL wrap_wr_err: got %b want 0", e); end
    read_capture(2'd0, 10'd5, 6'd0, 6'd0, e);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (cap_data[k] !== 16'h4010 + 16'(k)) begin
        miscompares++;
        $display("FAIL wrap_low[%0d]: got %h want %h", k, cap_data[k], 16'h4010 + 16'(k));
      end
    end
    read_capture(2'd3, 10'd9, 6'd63, 6'd1, e);
    vectors++;
    if ({e, cap_bad, cap_n, cap_first} !== {2'b00, 32'd32, 32'(RL)}) begin
      miscompares++;
      $display("FAIL wrap_rd32: got err=%b bad=%b beats=%0d first=%0d want 0 0 32 %0d",
               e, cap_bad, cap_n, cap_first, RL);
    end
    for (int k = 0; k < 32; k += 7) begin
      vectors++;
      if (cap_data[k] !== 16'h4000 + 16'(k)) begin
        miscompares++;
        $display("FAIL wrap_rd32[%0d]: got %h want %h", k, cap_data[k], 16'h4000 + 16'(k));
      end
    end
  endtask

  task automatic test_errors();
    logic e;
    send_cmd(4'd1, 2'd2, 10'd7, 6'd0, 6'd0);
    tick();
    write_burst(2'd2, 10'd7, 6'd0, 6'd0, 16'h6000, 16, e);
    send_cmd(4'd4, 2'd2, 10'd7, 6'd0, 6'd0);
    vectors++;
    if ({err, busy} !== 2'b00) begin miscompares++; $display("FAIL pre_err_busy: got %b want 00", {err, busy}); end
    tick();
    write_burst(2'd2, 10'd7, 6'd0, 6'd0, 16'h5500, 16, e);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL precharged_wr_err: got %b want 1", e); end
    send_cmd(4'd1, 2'd2, 10'd7, 6'd0, 6'd0);
    tick();
    read_capture(2'd2, 10'd7, 6'd0, 6'd0, e);
    for (int k = 0; k < 16; k += 5) begin
      vectors++;
      if (cap_data[k] !== 16'h6000 + 16'(k)) begin
        miscompares++;
        $display("FAIL dropped_wr_mem[%0d]: got %h want %h", k, cap_data[k], 16'h6000 + 16'(k));
      end
    end
    send_cmd(4'hF, 2'd0, 10'd0, 6'd0, 6'd0);
    vectors++;
    if ({err, busy} !== 2'b10) begin miscompares++; $display("FAIL badop: got err,busy=%b want 10", {err, busy}); end
    tick();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL badop_pulse: got %b want 0", err); end
    stb  = 1'b1;
    db_i = 16'hF000;
    tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL beat0_busy: got %b want 1", busy); end
    stb  = 1'b0;
    db_i = '0;
    tick();
    vectors++;
    if ({err, busy} !== 2'b00) begin miscompares++; $display("FAIL stb_drop: got err,busy=%b want 00", {err, busy}); end
    tick();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL stb_drop_late: got %b want 0", err); end
  endtask

  task automatic test_reset_mid_read();
    send_cmd(4'd3, 2'd0, 10'd5, 6'd2, 6'd0);
    repeat (RL + 4) tick();
    vectors++;
    if ({dqs_o, db_oe, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL midread_active: got dqs,oe,busy=%b want 111", {dqs_o, db_oe, busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({db_o, dqs_o, db_oe, dqs_oe, err, busy} !== 21'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", {db_o, dqs_o, db_oe, dqs_oe, err, busy});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_cmd(4'd3, 2'd0, 10'd5, 6'd2, 6'd0);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL post_reset_closed: got %b want 1", err); end
    repeat (RL + 18) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rd_closed();
    test_cs_abort();
    test_wrap();
    test_errors();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
